seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned M_DEF = 8;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned M = M_DEF
) (
    input  logic [M-1:0] prem,
    input  logic         bit_in,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] prem_nx,
    output logic         qbit
);

    logic [M:0] trial;
    logic [M:0] diff;

    // The kept value always fits in M bits: it is below the divisor either way.
    always_comb begin
        trial   = {prem, bit_in};
        diff    = trial - {1'b0, divisor};
        qbit    = (trial >= {1'b0, divisor});
        prem_nx = M'(qbit ? diff : trial);
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t        state, state_nx;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_nx;
    logic [M-1:0]  dvs_r;
    logic [M-1:0]  prem;
    logic [M-1:0]  prem_nx;
    logic          qbit;
    logic [CW-1:0] cnt;
    logic          last;

    // shreg holds the unconsumed dividend bits on the left and collects quotient bits on the right.
    assign shreg_nx = (shreg << 1) | N'(qbit);
    assign last     = (cnt == CW'(N - 1));

    div_step #(
        .M(M)
    ) u_step (
        .prem    (prem),
        .bit_in  (shreg[N-1]),
        .divisor (dvs_r),
        .prem_nx (prem_nx),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (divisor == '0) ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            dvs_r       <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= dividend;
                        dvs_r <= divisor;
                        prem  <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    shreg <= shreg_nx;
                    prem  <= prem_nx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        quotient    <= shreg_nx;
                        remainder   <= prem_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned N = 16;
    localparam int unsigned M = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] prev_q;
    logic [M-1:0] prev_r;
    logic         prev_z;

    seq_divider #(
        .N(N),
        .M(M)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One division; inj_at pulses a spurious start in that cycle, start_in_done pokes start during DONE.
    task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b,
                          input int inj_at, input bit start_in_done, input string tag);
        logic [N-1:0] eq;
        logic [M-1:0] er;
        logic         ez;
        int           exp_lat;
        int           cyc;
        bit           seen;
        if (b == 0) begin
            eq = '1; er = '0; ez = 1'b1; exp_lat = 1;
        end else begin
            eq = a / N'(b); er = M'(a % N'(b)); ez = 1'b0; exp_lat = N + 1;
        end
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = N'($urandom); divisor = M'($urandom);
        cyc = 1; seen = 0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1;
            end else begin
                if (cyc == 2) begin
                    check({tag, "_busy"}, busy, 1);
                    check({tag, "_hold_q"}, quotient, prev_q);
                    check({tag, "_hold_r"}, remainder, prev_r);
                    check({tag, "_hold_z"}, div_by_zero, prev_z);
                end
                if (cyc == inj_at) begin
                    start = 1'b1; dividend = N'($urandom); divisor = M'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        check({tag, "_busy_done"}, busy, 1);
        if (start_in_done) begin
            start = 1'b1; dividend = N'($urandom); divisor = M'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        prev_q = eq; prev_r = er; prev_z = ez;
    endtask

    initial begin
        int ndone;
        logic [N-1:0] a;
        logic [M-1:0] b;
        int sel;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        prev_q = '0; prev_r = '0; prev_z = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        run_op(16'd1000, 8'd7, 0, 0, "d1000_7");
        run_op(16'hFFFF, 8'd1, 0, 0, "dffff_1");
        run_op(16'h00FF, 8'h10, 0, 0, "d00ff_10");
        run_op(16'd1234, 8'd0, 0, 0, "d1234_0");
        run_op(16'd10, 8'd3, 0, 1, "d10_3");

        // A start pulse mid-operation must be ignored entirely.
        run_op(16'd100, 8'd9, 5, 0, "d100_9");
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignored_start_done", ndone, 0);

        // Reset in the middle of CALC abandons the operation.
        @(negedge clk);
        start = 1'b1; dividend = 16'hABCD; divisor = 8'h0D;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        prev_q = '0; prev_r = '0; prev_z = 1'b0;
        run_op(16'd200, 8'd200, 0, 0, "d200_200");

        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 15));
            a = N'($urandom);
            b = M'($urandom);
            if (sel == 0) b = '0;
            if (sel == 1 && b != 0) a = N'($urandom_range(0, int'(b) - 1));
            if (sel == 2) b = M'($urandom_range(1, 3));
            if (sel == 3) a = '0;
            run_op(a, b, int'($urandom_range(0, 24)), ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
